fire_scheduler: RTL and testbench
=================================

# fire_scheduler

Drives the `fire` index consumed by `circuit_inner`, so the synchronous circuit model can run in simulation and emulation, not only under a model checker that leaves `fire` unbound. Each cycle it picks one excited signal to fire: a signal is excited when its `_precap` value differs from its `Q`. The choice is pseudo-random and reproducible from a seed. A starvation guard and a quiescence detector guarantee fairness and report stable states.

## Interface
- `N`, 4: number of fireable signals (indices `0..N-1`), 1..255.
- `FIREBITS`, 3: width of `fire`. Must satisfy `2**FIREBITS > N`.
- `SEED`, 16'hACE1: LFSR reset value. 0 is replaced by 1.
- `STARVE_LIMIT`, 8: age that triggers a forced fire. 0 disables the guard.
- `AGE_W`, 8: per-index age counter width. `2**AGE_W > STARVE_LIMIT`.
- `QUIET_CYCLES`, 8: consecutive idle cycles before `quiescent` asserts (≥1).
- `STEP_W`, 16: step counter width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `excited` in N: bit i = 1 when signal i is excited.
- `hold` in 1: pause scheduling.
- `fire` out FIREBITS: index to fire. IDLE = all ones.
- `fire_valid` out 1: `fire` names a real index this cycle.
- `starve_forced` out 1: this cycle's pick came from the starvation guard.
- `quiescent` out 1: no excitation for `QUIET_CYCLES` cycles (registered).
- `step_count` out STEP_W: number of valid fires since reset, saturating.

## Operation
- State registers:
  - `lfsr[15:0]`
  - `age[i]`, one `AGE_W`-bit counter per index
  - `quiet_cnt`, saturating at `QUIET_CYCLES`
  - `quiescent`
  - `step_count`
- Reset values: `lfsr=SEED` (or 1 if `SEED` is 0), all ages 0, `quiet_cnt=0`, `quiescent=0`, `step_count=0`.
- Combinational outputs during reset: `fire=IDLE`, `fire_valid=0`, `starve_forced=0`.
- LFSR: Galois, shift right. If `lfsr[0]` is set, XOR with 16'hB400 after the shift. Advances every clock with `hold=0`.
- Start point: `start = (lfsr[7:0] * N) >> 8`, range 0..N-1.
- Selection, combinational from registered state and `excited`, in priority order:
  1. `hold=1` or `excited==0`: `fire=IDLE`, `fire_valid=0`.
  2. `STARVE_LIMIT>0` and some index has `excited[i]=1` with `age[i] >= STARVE_LIMIT`: fire the lowest such i, `starve_forced=1`.
  3. Otherwise: fire the first excited index at or after `start`, scanning upward and wrapping N-1→0. `starve_forced=0`.
- Age update, on each clock with `hold=0`:
  - `age[i]` is cleared to 0 if i is fired or not excited.
  - Otherwise it increments, saturating at `STARVE_LIMIT`.
- Quiescence, on each clock with `hold=0`:
  - `excited==0`: `quiet_cnt` increments, saturating.
  - Otherwise: `quiet_cnt` is cleared to 0.
  - `quiescent` register updates to `(next quiet_cnt == QUIET_CYCLES)`.
- `step_count` increments when `fire_valid=1`, saturating at all ones.
- `hold=1` freezes every register: lfsr, ages, quiet_cnt, quiescent, step_count.
- The scheduler never names an unexcited index, and never drives a value in N..IDLE-1.

## Timing
- Zero-latency pick: `fire` is valid in the same cycle as `excited`. The target DFF captures on the next `clk` edge.
- No combinational path from `fire` back to `excited` exists inside this block.
- Reset is asynchronous: on assertion, registers and outputs go to reset values without a clock edge. First pick occurs in the first cycle after deassertion.
- Fairness bound: a continuously excited index is fired within `STARVE_LIMIT+N` cycles (non-held cycles).
- `quiescent` rises on the `QUIET_CYCLES`-th consecutive idle edge. It falls on the first edge at which `excited!=0`.
- Simultaneous starvation: the lowest index wins. The remaining starved indices follow on subsequent cycles.

## Test plan
- Reset: with `reset=1`, `fire=3'b111`, `fire_valid=0`, `quiescent=0`, `step_count=0`. Drive `excited=4'b1111` during reset → `fire` stays 7.
- Single excitation: `excited=4'b0100` for 10 cycles → `fire=2` and `fire_valid=1` every cycle. `step_count` reaches 10.
- Quiescence (`QUIET_CYCLES=8`): `excited=0` → `quiescent` rises exactly at the 8th edge. Then `excited=4'b0001` → `fire=0`, and `quiescent` falls at the next edge.
- Fairness (`STARVE_LIMIT=3`): `excited=4'b1111` for 500 cycles.
  - Every index is fired within every 7-cycle window.
  - The `fire` and `starve_forced` sequences match the reference model from `SEED=16'hACE1`.
- Hold: assert `hold` for 5 cycles mid-run → `fire=7`, `fire_valid=0`, `step_count` unchanged. After release, the `fire` sequence equals the unheld run with the 5 cycles removed.
- Async reset mid-run: pulse `reset` between clock edges → outputs return to reset values immediately. The post-release `fire` sequence is identical to the first post-reset run.

Source files
------------

// File: rtl/fire_scheduler_if.sv
// Handshake bundle between fire_scheduler and the circuit model it drives.
// The circuit side reports excitation and hold; the scheduler returns the pick and status.
interface fire_scheduler_if #(
    parameter int unsigned N        = 4,
    parameter int unsigned FIREBITS = 3,
    parameter int unsigned STEP_W   = 16
);
    logic [N-1:0]        excited;
    logic                hold;
    logic [FIREBITS-1:0] fire;
    logic                fire_valid;
    logic                starve_forced;
    logic                quiescent;
    logic [STEP_W-1:0]   step_count;

    modport master (
        output excited, hold,
        input  fire, fire_valid, starve_forced, quiescent, step_count
    );

    modport slave (
        input  excited, hold,
        output fire, fire_valid, starve_forced, quiescent, step_count
    );
endinterface

// File: rtl/fire_scheduler.sv
// Picks one excited signal per cycle: LFSR-seeded rotating scan plus a starvation guard,
// with a registered quiescence detector and a saturating fire counter.
module fire_scheduler #(
    parameter int unsigned N            = 4,
    parameter int unsigned FIREBITS     = 3,
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned AGE_W        = 8,
    parameter int unsigned QUIET_CYCLES = 8,
    parameter int unsigned STEP_W       = 16
) (
    input  logic           clk,
    input  logic           reset,
    fire_scheduler_if.slave sif
);
    localparam int unsigned         QW        = $clog2(QUIET_CYCLES + 1);
    localparam logic [FIREBITS-1:0] IDLE      = '1;
    localparam logic [15:0]         LFSR_INIT = (SEED == 16'h0) ? 16'h0001 : SEED;
    localparam logic [AGE_W-1:0]    LIMIT     = AGE_W'(STARVE_LIMIT);
    localparam logic [QW-1:0]       QUIET_MAX = QW'(QUIET_CYCLES);

    logic [15:0]       lfsr_q, lfsr_d;
    logic [AGE_W-1:0]  age_q [N];
    logic [AGE_W-1:0]  age_d [N];
    logic [QW-1:0]     quiet_cnt_q, quiet_cnt_d;
    logic              quiescent_q, quiescent_d;
    logic [STEP_W-1:0] step_count_q, step_count_d;

    logic                pick_valid;
    logic                pick_forced;
    logic [FIREBITS-1:0] pick_idx;
    logic                scan_found;
    int unsigned         start_idx;
    int unsigned         scan_idx;

    // Selection: starved indices win (lowest first), otherwise a wrapped scan from the LFSR start.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        pick_valid  = 1'b0;
        pick_forced = 1'b0;
        pick_idx    = '0;
        scan_found  = 1'b0;
        scan_idx    = 0;
        start_idx   = int'((16'(lfsr_q[7:0]) * 16'(N)) >> 8);
        if (!reset && !sif.hold && (sif.excited != '0)) begin
            pick_valid = 1'b1;
            for (int i = 0; i < int'(N); i++) begin
                if (STARVE_LIMIT > 0 && !pick_forced && sif.excited[i] && age_q[i] >= LIMIT) begin
                    pick_forced = 1'b1;
                    pick_idx    = FIREBITS'(i);
                end
            end
            if (!pick_forced) begin
                for (int k = 0; k < int'(N); k++) begin
                    scan_idx = start_idx + k;
                    if (scan_idx >= N) scan_idx = scan_idx - N;
                    if (!scan_found && sif.excited[scan_idx]) begin
                        scan_found = 1'b1;
                        pick_idx   = FIREBITS'(scan_idx);
                    end
                end
            end
        end
    end

    assign sif.fire          = pick_valid ? pick_idx : IDLE;
    assign sif.fire_valid    = pick_valid;
    assign sif.starve_forced = pick_forced;
    assign sif.quiescent     = quiescent_q;
    assign sif.step_count    = step_count_q;

    always_comb begin
        lfsr_d       = lfsr_q;
        age_d        = age_q;
        quiet_cnt_d  = quiet_cnt_q;
        quiescent_d  = quiescent_q;
        step_count_d = step_count_q;
        if (!sif.hold) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
            for (int i = 0; i < int'(N); i++) begin
                if (!sif.excited[i] || (pick_valid && pick_idx == FIREBITS'(i)))
                    age_d[i] = '0;
                else if (age_q[i] < LIMIT)
                    age_d[i] = age_q[i] + AGE_W'(1);
            end
            if (sif.excited == '0) begin
                if (quiet_cnt_q < QUIET_MAX) quiet_cnt_d = quiet_cnt_q + QW'(1);
            end else begin
                quiet_cnt_d = '0;
            end
            quiescent_d = (quiet_cnt_d == QUIET_MAX);
            if (pick_valid && step_count_q != '1) step_count_d = step_count_q + STEP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q       <= LFSR_INIT;
            // NOTE: the age array is ordinary flops, so it is reset with everything else.
            age_q        <= '{default: '0};
            quiet_cnt_q  <= '0;
            quiescent_q  <= 1'b0;
            step_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge state.
            lfsr_q       <= lfsr_d;
            age_q        <= age_d;
            quiet_cnt_q  <= quiet_cnt_d;
            quiescent_q  <= quiescent_d;
            step_count_q <= step_count_d;
        end
    end
endmodule

// File: tb/tb_fire_scheduler.sv
// Self-checking bench for fire_scheduler: a behavioural model feeds an expectation
// queue each cycle, plus scenario checks for reset, quiescence, fairness, hold and async reset.
module tb_fire_scheduler;
    localparam int          N            = 4;
    localparam int          FIREBITS     = 3;
    localparam int          STEP_W       = 16;
    localparam int          STARVE_LIMIT = 3;
    localparam int          QUIET_CYCLES = 8;
    localparam logic [15:0] SEED         = 16'hACE1;

    typedef struct {
        logic [2:0]  fire;
        logic        valid;
        logic        forced;
        logic        quiet;
        logic [15:0] step;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    exp_t       sb[$];
    logic [2:0] fire_log[$];

    logic [15:0] m_lfsr;
    int          m_age[N];
    int          m_qcnt;
    logic        m_quiet;
    int          m_step;

    fire_scheduler_if #(.N(N), .FIREBITS(FIREBITS), .STEP_W(STEP_W)) sif ();

    fire_scheduler #(
        .N(N), .FIREBITS(FIREBITS), .SEED(SEED), .STARVE_LIMIT(STARVE_LIMIT),
        .AGE_W(8), .QUIET_CYCLES(QUIET_CYCLES), .STEP_W(STEP_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sif(sif.slave)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_lfsr = SEED;
        for (int i = 0; i < N; i++) m_age[i] = 0;
        m_qcnt  = 0;
        m_quiet = 1'b0;
        m_step  = 0;
    endfunction

    function automatic exp_t model_pick(logic [N-1:0] exc, logic h);
        exp_t e;
        e.fire   = 3'b111;
        e.valid  = 1'b0;
        e.forced = 1'b0;
        e.quiet  = m_quiet;
        e.step   = 16'(m_step);
        if (!h && exc != '0) begin
            int s;
            e.valid = 1'b1;
            for (int i = 0; i < N; i++)
                if (!e.forced && exc[i] && m_age[i] >= STARVE_LIMIT) begin
                    e.forced = 1'b1;
                    e.fire   = 3'(i);
                end
            if (!e.forced) begin
                s = (int'(m_lfsr[7:0]) * N) / 256;
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (s + k) % N;
                    if (exc[j]) begin
                        e.fire = 3'(j);
                        break;
                    end
                end
            end
        end
        return e;
    endfunction

    function automatic void model_advance(logic [N-1:0] exc, logic h, exp_t e);
        if (h) return;
        for (int i = 0; i < N; i++) begin
            if (!exc[i] || (e.valid && int'(e.fire) == i)) m_age[i] = 0;
            else if (m_age[i] < STARVE_LIMIT)             m_age[i] = m_age[i] + 1;
        end
        if (exc == '0) begin
            if (m_qcnt < QUIET_CYCLES) m_qcnt = m_qcnt + 1;
        end else begin
            m_qcnt = 0;
        end
        m_quiet = (m_qcnt == QUIET_CYCLES);
        if (e.valid && m_step < 65535) m_step = m_step + 1;
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    endfunction

    // Called just after a rising edge: drive, queue the expectation, compare at the falling edge.
    task automatic run_cycle(input logic [N-1:0] exc, input logic h, input string tag);
        exp_t e;
        sif.excited = exc;
        sif.hold    = h;
        sb.push_back(model_pick(exc, h));
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (sif.fire !== e.fire) begin
            errors++;
            $display("FAIL %s fire: got %0d expected %0d", tag, sif.fire, e.fire);
        end
        checks++;
        if (sif.fire_valid !== e.valid) begin
            errors++;
            $display("FAIL %s fire_valid: got %b expected %b", tag, sif.fire_valid, e.valid);
        end
        checks++;
        if (sif.starve_forced !== e.forced) begin
            errors++;
            $display("FAIL %s starve_forced: got %b expected %b", tag, sif.starve_forced, e.forced);
        end
        checks++;
        if (sif.quiescent !== e.quiet) begin
            errors++;
            $display("FAIL %s quiescent: got %b expected %b", tag, sif.quiescent, e.quiet);
        end
        checks++;
        if (sif.step_count !== e.step) begin
            errors++;
            $display("FAIL %s step_count: got %0d expected %0d", tag, sif.step_count, e.step);
        end
        fire_log.push_back(sif.fire);
        @(posedge clk);
        model_advance(exc, h, e);
        #1;
    endtask

    task automatic apply_reset();
        sif.excited = '1;
        sif.hold    = 1'b0;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        sb.delete();
        fire_log.delete();
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        sif.excited = 4'b1111;
        sif.hold    = 1'b0;
        #2;
        checks++;
        if (sif.fire !== 3'b111 || sif.fire_valid !== 1'b0 || sif.starve_forced !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got fire=%0d valid=%b forced=%b expected fire=7 valid=0 forced=0",
                     sif.fire, sif.fire_valid, sif.starve_forced);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sif.fire !== 3'b111 || sif.quiescent !== 1'b0 || sif.step_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got fire=%0d quiescent=%b step=%0d expected 7 0 0",
                     sif.fire, sif.quiescent, sif.step_count);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single_excitation();
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            run_cycle(4'b0100, 1'b0, "single");
            checks++;
            if (sif.fire !== 3'd2 || sif.fire_valid !== 1'b1) begin
                errors++;
                $display("FAIL single_pick: got fire=%0d valid=%b expected fire=2 valid=1",
                         sif.fire, sif.fire_valid);
            end
        end
        checks++;
        if (sif.step_count !== 16'd10) begin
            errors++;
            $display("FAIL single_steps: got %0d expected 10", sif.step_count);
        end
    endtask

    task automatic test_quiescence();
        apply_reset();
        for (int edges = 1; edges <= 10; edges++) begin
            run_cycle(4'b0000, 1'b0, "quiet");
            checks++;
            if (sif.quiescent !== (edges >= QUIET_CYCLES)) begin
                errors++;
                $display("FAIL quiet_rise: after %0d idle edges got %b expected %b",
                         edges, sif.quiescent, (edges >= QUIET_CYCLES));
            end
        end
        run_cycle(4'b0001, 1'b0, "quiet_exit");
        checks++;
        if (sif.quiescent !== 1'b0) begin
            errors++;
            $display("FAIL quiet_fall: got %b expected 0", sif.quiescent);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] seen;
        apply_reset();
        for (int c = 0; c < 500; c++) run_cycle(4'b1111, 1'b0, "fair");
        for (int w = 0; w + STARVE_LIMIT + N <= fire_log.size(); w++) begin
            seen = '0;
            for (int k = 0; k < STARVE_LIMIT + N; k++)
                if (fire_log[w+k] < 3'(N)) seen[fire_log[w+k]] = 1'b1;
            checks++;
            if (seen !== 4'b1111) begin
                errors++;
                $display("FAIL fair_window: window at %0d fired set %b expected 1111", w, seen);
            end
        end
    endtask

    task automatic test_hold();
        logic [2:0]  ref_seq[$];
        logic [2:0]  got_seq[$];
        logic [15:0] saved_step;
        apply_reset();
        for (int c = 0; c < 20; c++) run_cycle(4'b1111, 1'b0, "hold_ref");
        ref_seq = fire_log;
        apply_reset();
        for (int c = 0; c < 10; c++) run_cycle(4'b1111, 1'b0, "hold_pre");
        got_seq    = fire_log;
        saved_step = sif.step_count;
        for (int c = 0; c < 5; c++) begin
            run_cycle(4'b1111, 1'b1, "hold_on");
            checks++;
            if (sif.fire !== 3'b111 || sif.fire_valid !== 1'b0 || sif.step_count !== saved_step) begin
                errors++;
                $display("FAIL hold_freeze: got fire=%0d valid=%b step=%0d expected fire=7 valid=0 step=%0d",
                         sif.fire, sif.fire_valid, sif.step_count, saved_step);
            end
        end
        fire_log.delete();
        for (int c = 0; c < 10; c++) run_cycle(4'b1111, 1'b0, "hold_post");
        foreach (fire_log[i]) got_seq.push_back(fire_log[i]);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (got_seq[i] !== ref_seq[i]) begin
                errors++;
                $display("FAIL hold_sequence: step %0d got %0d expected %0d", i, got_seq[i], ref_seq[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] first_seq[$];
        apply_reset();
        for (int c = 0; c < 12; c++) run_cycle(4'b1111, 1'b0, "arst_first");
        first_seq = fire_log;
        for (int c = 0; c < 5; c++) run_cycle(4'b1111, 1'b0, "arst_mid");
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (sif.fire !== 3'b111 || sif.fire_valid !== 1'b0 || sif.starve_forced !== 1'b0 ||
            sif.quiescent !== 1'b0 || sif.step_count !== 16'd0) begin
            errors++;
            $display("FAIL arst_immediate: got fire=%0d valid=%b forced=%b quiet=%b step=%0d expected 7 0 0 0 0",
                     sif.fire, sif.fire_valid, sif.starve_forced, sif.quiescent, sif.step_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        sb.delete();
        fire_log.delete();
        for (int c = 0; c < 12; c++) run_cycle(4'b1111, 1'b0, "arst_second");
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (fire_log[i] !== first_seq[i]) begin
                errors++;
                $display("FAIL arst_sequence: step %0d got %0d expected %0d", i, fire_log[i], first_seq[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_excitation();
        test_quiescence();
        test_fairness();
        test_hold();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
